// File: rtl/upsampling_layer_pkg.sv
// Shared definitions for the upsampling layer: counter-width macro and FSM state encoding.
`ifndef UPSAMPLING_LAYER_DEFS
`define UPSAMPLING_LAYER_DEFS
`define LOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package upsampling_layer_pkg;
  typedef enum logic {
    UPS_LIVE   = 1'b0,
    UPS_REPLAY = 1'b1
  } ups_state_e;
endpackage

// File: rtl/upsample_row_buffer.sv
// Single-row pixel store: synchronous write, combinational read, used to replay rows vertically.
module upsample_row_buffer
  import upsampling_layer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     clk_en,
  input  logic                     wr_en,
  input  logic [`LOG2(DEPTH)-1:0]  wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [`LOG2(DEPTH)-1:0]  rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clk_en && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/upsampling_layer.sv
// Nearest-neighbour upsampler: replicates each input pixel SCALE times per axis,
// replaying buffered rows while the input is stalled.
module upsampling_layer
  import upsampling_layer_pkg::*;
#(
  parameter int D_WIDTH    = 8,
  parameter int CHANNELS   = 1,
  parameter int IMAGE_SIZE = 4,
  parameter int SCALE      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_en,
  input  logic [D_WIDTH*CHANNELS-1:0]   input_data,
  input  logic                          input_valid,
  output logic                          input_ready,
  output logic [D_WIDTH*CHANNELS-1:0]   output_data,
  output logic                          valid,
  output logic                          last
);

  localparam int PW = D_WIDTH * CHANNELS;
  localparam int CW = `LOG2(IMAGE_SIZE);
  localparam int SW = `LOG2(SCALE);
  localparam logic [CW-1:0] COL_MAX = CW'(IMAGE_SIZE - 1);
  localparam logic [SW-1:0] REP_MAX = SW'(SCALE - 1);

  ups_state_e      state_p0, state_nxt;
  logic [CW-1:0]   col_p0, row_p0, col_nxt, row_nxt;
  logic [SW-1:0]   hrep_p0, vrep_p0, hrep_nxt, vrep_nxt;
  logic [PW-1:0]   data_p1, buf_rd;
  logic            vld_p1, last_p1;
  logic            live_head, accept, advance, at_end;

  assign live_head   = (state_p0 == UPS_LIVE) && (hrep_p0 == '0);
  assign input_ready = clk_en & ~rst & live_head;
  assign accept      = input_ready & input_valid;
  // Only a fresh-pixel slot can stall; every replicated copy always advances.
  assign advance     = accept | ~live_head;
  assign at_end      = (row_p0 == COL_MAX) && (vrep_p0 == REP_MAX) &&
                       (col_p0 == COL_MAX) && (hrep_p0 == REP_MAX);

  always_comb begin
    hrep_nxt  = hrep_p0;
    col_nxt   = col_p0;
    vrep_nxt  = vrep_p0;
    row_nxt   = row_p0;
    state_nxt = state_p0;
    if (advance) begin
      if (hrep_p0 != REP_MAX) begin
        hrep_nxt = hrep_p0 + SW'(1);
      end else begin
        hrep_nxt = '0;
        if (col_p0 != COL_MAX) begin
          col_nxt = col_p0 + CW'(1);
        end else begin
          col_nxt = '0;
          if (vrep_p0 != REP_MAX) begin
            vrep_nxt = vrep_p0 + SW'(1);
          end else begin
            vrep_nxt = '0;
            row_nxt  = (row_p0 == COL_MAX) ? '0 : row_p0 + CW'(1);
          end
        end
      end
      state_nxt = (vrep_nxt == '0) ? UPS_LIVE : UPS_REPLAY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= UPS_LIVE;
      col_p0   <= '0;
      hrep_p0  <= '0;
      vrep_p0  <= '0;
      row_p0   <= '0;
    end else if (clk_en) begin
      state_p0 <= state_nxt;
      col_p0   <= col_nxt;
      hrep_p0  <= hrep_nxt;
      vrep_p0  <= vrep_nxt;
      row_p0   <= row_nxt;
    end
  end

  upsample_row_buffer #(
    .DEPTH (IMAGE_SIZE),
    .WIDTH (PW)
  ) u_row_buffer (
    .clk     (clk),
    .clk_en  (clk_en),
    .wr_en   (accept),
    .wr_addr (col_p0),
    .wr_data (input_data),
    .rd_addr (col_p0),
    .rd_data (buf_rd)
  );

  // Stage p1: registered output pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (clk_en) begin
      if (state_p0 == UPS_REPLAY) begin
        data_p1 <= buf_rd;
        vld_p1  <= 1'b1;
        last_p1 <= at_end;
      end else if (hrep_p0 != '0) begin
        vld_p1  <= 1'b1;
        last_p1 <= at_end;
      end else if (accept) begin
        data_p1 <= input_data;
        vld_p1  <= 1'b1;
        last_p1 <= at_end;
      end else begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
    end
  end

  assign output_data = data_p1;
  assign valid       = vld_p1;
  assign last        = last_p1;

endmodule

// File: tb/tb_upsampling_layer.sv
// Self-checking bench for upsampling_layer: three configurations driven from shared stimulus.
module tb_upsampling_layer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b0;
  logic        input_valid = 1'b0;
  logic [23:0] din = '0;

  logic [7:0]  a_data, c_data;
  logic [23:0] b_data;
  logic        a_ready, a_valid, a_last;
  logic        b_ready, b_valid, b_last;
  logic        c_ready, c_valid, c_last;

  always #5 clk = ~clk;

  upsampling_layer #(.D_WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(2), .SCALE(2)) u_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .input_data(din[7:0]), .input_valid(input_valid),
    .input_ready(a_ready), .output_data(a_data), .valid(a_valid), .last(a_last));

  upsampling_layer #(.D_WIDTH(8), .CHANNELS(3), .IMAGE_SIZE(4), .SCALE(3)) u_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .input_data(din), .input_valid(input_valid),
    .input_ready(b_ready), .output_data(b_data), .valid(b_valid), .last(b_last));

  upsampling_layer #(.D_WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(4), .SCALE(1)) u_c (
    .clk(clk), .rst(rst), .clk_en(clk_en), .input_data(din[7:0]), .input_valid(input_valid),
    .input_ready(c_ready), .output_data(c_data), .valid(c_valid), .last(c_last));

  int          sel = 0;
  logic [23:0] obs_data;
  logic        obs_valid, obs_last, obs_ready;

  always_comb begin
    obs_data  = {16'h0, a_data};
    obs_valid = a_valid;
    obs_last  = a_last;
    obs_ready = a_ready;
    if (sel == 1) begin
      obs_data = b_data; obs_valid = b_valid; obs_last = b_last; obs_ready = b_ready;
    end else if (sel == 2) begin
      obs_data = {16'h0, c_data}; obs_valid = c_valid; obs_last = c_last; obs_ready = c_ready;
    end
  end

  int          n_checks = 0;
  int          n_pass = 0;
  logic [23:0] in_q[$];
  logic [23:0] exp_q[$];
  bit          exp_last[$];
  bit          rdy_hist[32];

  // Reference: each frame is a raster of input pixels; every pixel appears sc x sc times.
  task automatic build_exp(input int is, input int sc, input int nfr);
    exp_q.delete();
    exp_last.delete();
    for (int f = 0; f < nfr; f++)
      for (int r = 0; r < is; r++)
        for (int vr = 0; vr < sc; vr++)
          for (int c = 0; c < is; c++)
            for (int hr = 0; hr < sc; hr++) begin
              exp_q.push_back(in_q[f*is*is + r*is + c]);
              exp_last.push_back(r == is-1 && vr == sc-1 && c == is-1 && hr == sc-1);
            end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clk_en = 1'b1; input_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic stream(input string name, input int max_out, input int bub_idx, input int bub_len,
                        input int frz_at, input int frz_len);
    int idx = 0, k = 0, gaps = 0, bub = 0, frz = 0, cyc = 0, lat = -1, total;
    bit acc, hist_on = 0, rdy;
    logic [23:0] h_data;
    logic h_valid, h_last;
    total = (max_out >= 0) ? max_out : exp_q.size();
    for (int i = 0; i < 32; i++) rdy_hist[i] = 0;
    for (int t = 0; t < 5000 && k < total; t++) begin
      @(negedge clk);
      if (frz_at >= 0 && k == frz_at && frz < frz_len) begin
        if (frz == 0) begin h_data = obs_data; h_valid = obs_valid; h_last = obs_last; end
        clk_en = 1'b0;
        frz++;
      end else begin
        clk_en = 1'b1;
      end
      #1;
      rdy = obs_ready;
      if (idx < in_q.size()) begin
        if (idx == bub_idx && bub < bub_len && rdy) begin
          input_valid = 1'b0; bub++;
        end else begin
          input_valid = 1'b1; din = in_q[idx];
        end
      end else begin
        input_valid = 1'b0;
      end
      if (!clk_en) begin
        n_checks++;
        if (rdy !== 1'b0) $display("FAIL %s ready_in_freeze got %b want 0", name, rdy);
        else n_pass++;
      end
      acc = rdy && input_valid;
      if (acc) hist_on = 1;
      if (hist_on) begin
        if (cyc < 32) rdy_hist[cyc] = rdy;
        cyc++;
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (!clk_en) begin
        n_checks++;
        if (obs_data !== h_data || obs_valid !== h_valid || obs_last !== h_last)
          $display("FAIL %s freeze_hold got %h/%b/%b want %h/%b/%b", name,
                   obs_data, obs_valid, obs_last, h_data, h_valid, h_last);
        else n_pass++;
      end else if (obs_valid === 1'b1) begin
        if (lat < 0) lat = cyc - 1;
        n_checks++;
        if (obs_data !== exp_q[k] || obs_last !== exp_last[k])
          $display("FAIL %s out[%0d] data/last got %h/%b want %h/%b", name, k,
                   obs_data, obs_last, exp_q[k], exp_last[k]);
        else n_pass++;
        k++;
      end else if (k > 0) begin
        gaps++;
      end
    end
    input_valid = 1'b0;
    clk_en = 1'b1;
    n_checks++;
    if (k != total) $display("FAIL %s out_count got %0d want %0d", name, k, total);
    else n_pass++;
    n_checks++;
    if (gaps != bub_len) $display("FAIL %s bubbles got %0d want %0d", name, gaps, bub_len);
    else n_pass++;
    n_checks++;
    if (lat != 0) $display("FAIL %s latency got %0d want 0", name, lat);
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; clk_en = 1'b0; input_valid = 1'b1;
    #1;
    n_checks++;
    if ({a_ready, b_ready, c_ready} !== 3'b000)
      $display("FAIL reset_ready got %b want 000", {a_ready, b_ready, c_ready});
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({a_valid, b_valid, c_valid, a_last, b_last, c_last} !== 6'b0)
      $display("FAIL reset_valid_last got %b want 000000",
               {a_valid, b_valid, c_valid, a_last, b_last, c_last});
    else n_pass++;
    n_checks++;
    if (a_data !== 8'h0 || b_data !== 24'h0 || c_data !== 8'h0)
      $display("FAIL reset_data got %h/%h/%h want 0", a_data, b_data, c_data);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; clk_en = 1'b1; input_valid = 1'b0;
    #1;
    n_checks++;
    if ({a_ready, b_ready, c_ready} !== 3'b111)
      $display("FAIL post_reset_ready got %b want 111", {a_ready, b_ready, c_ready});
    else n_pass++;
  endtask

  task automatic test_basic();
    bit want;
    sel = 0;
    do_reset();
    in_q = '{24'd1, 24'd2, 24'd3, 24'd4};
    build_exp(2, 2, 1);
    stream("basic", -1, -1, 0, -1, 0);
    for (int i = 0; i < 16; i++) begin
      want = (i == 0 || i == 2 || i == 8 || i == 10);
      n_checks++;
      if (rdy_hist[i] !== want) $display("FAIL basic ready[%0d] got %b want %b", i, rdy_hist[i], want);
      else n_pass++;
    end
  endtask

  task automatic test_bubble();
    sel = 0;
    do_reset();
    in_q = '{24'd1, 24'd2, 24'd3, 24'd4};
    build_exp(2, 2, 1);
    stream("bubble", -1, 1, 3, -1, 0);
  endtask

  task automatic test_freeze();
    sel = 0;
    do_reset();
    in_q = '{24'd1, 24'd2, 24'd3, 24'd4};
    build_exp(2, 2, 1);
    stream("freeze", -1, -1, 0, 5, 4);
  endtask

  task automatic test_reset_mid();
    sel = 0;
    do_reset();
    in_q = '{24'd1, 24'd2, 24'd3, 24'd4};
    build_exp(2, 2, 1);
    stream("pre_reset", 6, -1, 0, -1, 0);
    @(negedge clk);
    rst = 1'b1; input_valid = 1'b1; din = 24'd5;
    #1;
    n_checks++;
    if (a_ready !== 1'b0) $display("FAIL midreset_ready got %b want 0", a_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (a_valid !== 1'b0 || a_last !== 1'b0)
      $display("FAIL midreset_valid_last got %b/%b want 0/0", a_valid, a_last);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; input_valid = 1'b0;
    in_q = '{24'd9, 24'd8, 24'd7, 24'd6};
    build_exp(2, 2, 1);
    stream("post_reset", -1, -1, 0, -1, 0);
  endtask

  task automatic test_back_to_back();
    sel = 0;
    do_reset();
    in_q.delete();
    for (int i = 0; i < 12; i++) in_q.push_back(24'($urandom_range(0, 255)));
    build_exp(2, 2, 3);
    stream("back_to_back", -1, -1, 0, -1, 0);
  endtask

  task automatic test_multichannel();
    sel = 1;
    do_reset();
    in_q.delete();
    for (int i = 0; i < 32; i++) in_q.push_back(24'($urandom));
    build_exp(4, 3, 2);
    stream("multichannel", -1, -1, 0, -1, 0);
  endtask

  task automatic test_passthrough();
    sel = 2;
    do_reset();
    in_q.delete();
    for (int i = 0; i < 16; i++) in_q.push_back(24'($urandom_range(0, 255)));
    build_exp(4, 1, 1);
    stream("passthrough", -1, -1, 0, -1, 0);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rdy_hist[i] !== 1'b1) $display("FAIL passthrough ready[%0d] got %b want 1", i, rdy_hist[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubble();
    test_freeze();
    test_reset_mid();
    test_back_to_back();
    test_multichannel();
    test_passthrough();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/upsampling_layer.md
Name: upsampling_layer

Overview:
- Nearest-neighbour upsampling (unpooling) layer; the inverse-direction counterpart of the max pooling layer in the CNN pipeline.
- Consumes a raster stream of an IMAGE_SIZE x IMAGE_SIZE multi-channel image, one pixel per cycle.
- Emits an (IMAGE_SIZE*SCALE)^2 raster in which every input pixel is replicated SCALE times horizontally and SCALE times vertically.
- A one-row buffer replays rows; the input is stalled via input_ready while replication is in progress.

Parameters:
D_WIDTH, 8, bits per channel sample
CHANNELS, 1, channels packed per pixel (channel i at bits [D_WIDTH*i +: D_WIDTH])
IMAGE_SIZE, 4, input image width and height in pixels (>=2)
SCALE, 2, replication factor per axis (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
clk_en  input  1  global enable; when low, all state holds
input_data  input  D_WIDTH*CHANNELS  input pixel
input_valid  input  1  input_data is valid this cycle
input_ready  output  1  block accepts input this cycle (combinational)
output_data  output  D_WIDTH*CHANNELS  output pixel (registered)
valid  output  1  output_data is valid (registered)
last  output  1  pulses with the final output pixel of a frame (registered)

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset, on a rising edge of clk with rst=1, regardless of clk_en:
  - output_data=0, valid=0, last=0.
  - Counters col, hrep, vrep and row all = 0; state=LIVE.
  - Row buffer contents are not cleared.
- Counter widths use the LOG2 macro from the shared definitions file.
- Counter ranges: col 0..IMAGE_SIZE-1, hrep 0..SCALE-1, vrep 0..SCALE-1, row 0..IMAGE_SIZE-1.
- States: LIVE (vrep==0, fresh input row) and REPLAY (vrep>=1, rows replayed from the buffer).
- input_ready = clk_en & ~rst & (state==LIVE) & (hrep==0).
- An input is accepted when input_ready & input_valid. Nothing below happens on cycles with clk_en=0.
- LIVE, hrep==0:
  - If the input is accepted: output_data<=input_data, valid<=1, buf[col]<=input_data, then advance.
  - If it is not accepted: valid<=0, last<=0, counters hold (bubble).
- LIVE, hrep>0: output_data holds, valid<=1, advance.
- REPLAY: output_data<=buf[col], valid<=1, advance. input_valid is ignored.
- Advance (nested wrap, innermost first):
  - hrep++ until SCALE-1, then hrep=0 and col++.
  - col wraps at IMAGE_SIZE-1, then col=0 and vrep++.
  - vrep wraps at SCALE-1, then vrep=0 and row++.
  - row wraps at IMAGE_SIZE-1, then row=0.
  - state = (next vrep==0) ? LIVE : REPLAY.
- last<=1 on the cycle that emits the pixel with row, vrep, col and hrep all at their maxima; last<=0 otherwise.
- Latency: 1 cycle from input acceptance to first output copy.
- Steady state with input_valid held high: exactly SCALE^2 output cycles per input pixel, with no bubbles in REPLAY.
- SCALE=1: pure registered pass-through; input_ready is high whenever clk_en & ~rst; state never leaves LIVE.
- clk_en=0: all registers hold, including valid, output_data and last. Downstream shares clk_en, so held values are not double-counted.
- Reset mid-frame: the frame is abandoned; the next accepted pixel is treated as pixel (0,0). No partial-frame flush.
- There is no output backpressure. Downstream must sustain one pixel per enabled cycle.

Decomposition:
- The shared definitions file holds the LOG2 macro and the state encodings (UPS_LIVE=0, UPS_REPLAY=1).
- One natural sub-module: upsample_row_buffer.
  - Parameters: DEPTH=IMAGE_SIZE, WIDTH=D_WIDTH*CHANNELS.
  - Synchronous write gated by clk_en & write enable; combinational read at rd_addr.
  - Address generation and the FSM stay in the top level.

Test Plan:
- Basic frame (IMAGE_SIZE=2, SCALE=2, CHANNELS=1, D_WIDTH=8), after reset, inputs 1,2,3,4 with input_valid held high -> outputs 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4 on 16 consecutive valid cycles. input_ready is high on output cycles 0,2,8,10 (relative to first acceptance); last is high only with the 16th output.
- Input bubble: hold input_valid=0 for 3 cycles before pixel 2 -> valid=0 for exactly those 3 cycles, then the sequence resumes unchanged with no duplicated or skipped pixel.
- clk_en freeze: drop clk_en for 4 cycles during REPLAY (while 1,1 repeats) -> output_data, valid and counters hold; input_ready=0; the sequence continues identically afterwards.
- Reset mid-frame: assert rst after output 6, then stream 9,8,7,6 -> valid=0 and last=0 the cycle after rst; output is 9,9,8,8,9,9,8,8,7,7,6,6,7,7,6,6.
- Multi-channel (CHANNELS=3, IMAGE_SIZE=4, SCALE=3): stream two random frames back-to-back -> 144 outputs per frame matching a reference model per channel, last on outputs 144 and 288, no gap between frames.
- Pass-through (SCALE=1): input_ready permanently high; outputs equal inputs delayed by 1 cycle; last coincides with the 16th pixel of a 4x4 frame.
